// File: rtl/riscv_segmmu_pkg.sv
// Shared types for the segment MMU: BIU access size, permission bit indices
// and the segment table entry layout.
package riscv_segmmu_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  // Bit positions inside the {W,R} permission field.
  localparam int PERM_R = 0;
  localparam int PERM_W = 1;

  // Entries hold addresses zero-extended to the widest supported width so one
  // struct serves every XLEN/PLEN combination up to 64 bits.
  localparam int SEG_AW = 64;

  typedef struct packed {
    logic              valid;
    logic [1:0]        perm;
    logic [SEG_AW-1:0] vbase;
    logic [SEG_AW-1:0] mask;
    logic [SEG_AW-1:0] pbase;
  } seg_entry_t;

endpackage

// File: rtl/riscv_segmmu_match.sv
// Combinational segment lookup: finds the lowest-index valid entry whose
// masked base equals the masked address and checks its permissions.
module riscv_segmmu_match
  import riscv_segmmu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REGIONS = 4,
  parameter int IW      = 2
) (
  input  seg_entry_t        i_table [REGIONS],
  input  logic [XLEN-1:0]   i_adr,
  input  logic              i_we,
  input  logic              i_lock,
  output logic              o_hit,
  output logic [IW-1:0]     o_idx,
  output logic              o_perm_ok
);

  logic [SEG_AW-1:0] w_adr;
  logic [1:0]        w_perm;

  assign w_adr = SEG_AW'(i_adr);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_perm = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (i_table[i].valid &&
          ((w_adr & i_table[i].mask) == (i_table[i].vbase & i_table[i].mask))) begin
        o_hit  = 1'b1;
        o_idx  = IW'(i);
        w_perm = i_table[i].perm;
      end
    end
    // Locked accesses are read-modify-write and need both rights.
    if (i_lock)    o_perm_ok = o_hit & w_perm[PERM_R] & w_perm[PERM_W];
    else if (i_we) o_perm_ok = o_hit & w_perm[PERM_W];
    else           o_perm_ok = o_hit & w_perm[PERM_R];
  end

endmodule

// File: rtl/riscv_segmmu.sv
// Segment MMU between address generation and the BIU. With enable_i=1 the
// virtual address is translated through a mask/base segment table and checked
// for permission; with enable_i=0 it is a bare pass-through. STAGES selects
// 1 or 2 register stages (any value other than 2 builds the 1-stage variant).
// Handshake: req_o is a single-cycle qualifier; pagefault_o replaces req_o for
// a faulting request; stall_i freezes everything, flush_i kills everything.
module riscv_segmmu
  import riscv_segmmu_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int PLEN    = XLEN,
  parameter  int REGIONS = 4,
  parameter  int STAGES  = 1,
  localparam int IW      = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            enable_i,
  input  logic            cfg_we_i,
  input  logic [IW-1:0]   cfg_idx_i,
  input  logic            cfg_valid_i,
  input  logic [1:0]      cfg_perm_i,
  input  logic [XLEN-1:0] cfg_vbase_i,
  input  logic [XLEN-1:0] cfg_mask_i,
  input  logic [PLEN-1:0] cfg_pbase_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] adr_i,
  input  biu_size_t       size_i,
  input  logic            lock_i,
  input  logic            we_i,
  output logic            req_o,
  output logic [PLEN-1:0] adr_o,
  output biu_size_t       size_o,
  output logic            lock_o,
  output logic            we_o,
  output logic            pagefault_o
);

  seg_entry_t      r_table [REGIONS];
  logic            w_hit;
  logic            w_perm_ok;
  logic            w_fault;
  logic [IW-1:0]   w_idx;

  logic            w_nx_req;
  logic            w_nx_pf;
  logic [PLEN-1:0] w_nx_adr;
  biu_size_t       w_nx_size;
  logic            w_nx_lock;
  logic            w_nx_we;

  // padr = (pbase & mask) | (adr & ~mask), everything sized to PLEN.
  function automatic logic [PLEN-1:0] f_padr(input seg_entry_t e, input logic [XLEN-1:0] a);
    logic [PLEN-1:0] m;
    m = PLEN'(e.mask);
    return (PLEN'(e.pbase) & m) | (PLEN'(a) & ~m);
  endfunction

  // Segment table; writes ignore stall and out-of-range indices.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REGIONS; i++) r_table[i] <= '0;
    end else if (cfg_we_i && (32'(cfg_idx_i) < 32'(REGIONS))) begin
      r_table[cfg_idx_i] <= '{valid: cfg_valid_i,
                              perm:  cfg_perm_i,
                              vbase: SEG_AW'(cfg_vbase_i),
                              mask:  SEG_AW'(cfg_mask_i),
                              pbase: SEG_AW'(cfg_pbase_i)};
    end
  end

  riscv_segmmu_match #(
    .XLEN    (XLEN),
    .REGIONS (REGIONS),
    .IW      (IW)
  ) u_match (
    .i_table   (r_table),
    .i_adr     (adr_i),
    .i_we      (we_i),
    .i_lock    (lock_i),
    .o_hit     (w_hit),
    .o_idx     (w_idx),
    .o_perm_ok (w_perm_ok)
  );

  assign w_fault = enable_i & req_i & ~(w_hit & w_perm_ok);

  generate
    if (STAGES == 2) begin : g_two
      logic            r1_valid;
      logic            r1_fault;
      logic            r1_en;
      logic [IW-1:0]   r1_idx;
      logic [XLEN-1:0] r1_adr;
      biu_size_t       r1_size;
      logic            r1_lock;
      logic            r1_we;

      // Stage 1: capture match index, fault and request attributes.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r1_valid <= 1'b0;
          r1_fault <= 1'b0;
          r1_en    <= 1'b0;
          r1_idx   <= '0;
          r1_adr   <= '0;
          r1_size  <= BYTE;
          r1_lock  <= 1'b0;
          r1_we    <= 1'b0;
        end else if (flush_i) begin
          r1_valid <= 1'b0;
          r1_fault <= 1'b0;
        end else if (!stall_i) begin
          r1_valid <= req_i;
          r1_fault <= w_fault;
          r1_en    <= enable_i;
          r1_idx   <= w_idx;
          r1_adr   <= adr_i;
          r1_size  <= size_i;
          r1_lock  <= lock_i;
          r1_we    <= we_i;
        end
      end

      // Stage 2 input: physical address formed from the registered index.
      always_comb begin
        w_nx_req  = r1_valid & ~r1_fault;
        w_nx_pf   = r1_valid & r1_fault;
        w_nx_adr  = (r1_en & ~r1_fault) ? f_padr(r_table[r1_idx], r1_adr) : PLEN'(r1_adr);
        w_nx_size = r1_size;
        w_nx_lock = r1_lock;
        w_nx_we   = r1_we;
      end
    end else begin : g_one
      // Single stage: match, translate and check all before the output register.
      always_comb begin
        w_nx_req  = req_i & ~w_fault;
        w_nx_pf   = w_fault;
        w_nx_adr  = (enable_i & ~w_fault) ? f_padr(r_table[w_idx], adr_i) : PLEN'(adr_i);
        w_nx_size = size_i;
        w_nx_lock = lock_i;
        w_nx_we   = we_i;
      end
    end
  endgenerate

  // Output register: flush clears the qualifiers, stall holds everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_o       <= 1'b0;
      pagefault_o <= 1'b0;
      adr_o       <= '0;
      size_o      <= BYTE;
      lock_o      <= 1'b0;
      we_o        <= 1'b0;
    end else if (flush_i) begin
      req_o       <= 1'b0;
      pagefault_o <= 1'b0;
    end else if (!stall_i) begin
      req_o       <= w_nx_req;
      pagefault_o <= w_nx_pf;
      adr_o       <= w_nx_adr;
      size_o      <= w_nx_size;
      lock_o      <= w_nx_lock;
      we_o        <= w_nx_we;
    end
  end

endmodule

// File: tb/tb_riscv_segmmu.sv
// Bench for riscv_segmmu: a 1-stage and a 2-stage instance share all inputs.
// Table-driven vectors run through a scoreboard on the 1-stage instance;
// hand-written sequences cover latency, stall, flush, config hazard and reset.
module tb_riscv_segmmu;
  import riscv_segmmu_pkg::*;

  localparam int W = 39;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, en;
  logic        cfg_we, cfg_valid;
  logic [1:0]  cfg_idx, cfg_perm;
  logic [31:0] cfg_vbase, cfg_mask, cfg_pbase;
  logic        req, lock, we;
  logic [31:0] adr;
  biu_size_t   sz;

  logic        o1_req, o1_pf, o1_lock, o1_we;
  logic [31:0] o1_adr;
  biu_size_t   o1_size;
  logic        o2_req, o2_pf, o2_lock, o2_we;
  logic [31:0] o2_adr;
  biu_size_t   o2_size;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_valid;
    logic [1:0]  cfg_perm;
    logic [31:0] cfg_vbase, cfg_mask, cfg_pbase;
    logic        en;
    logic [31:0] adr;
    logic        we, lock;
    biu_size_t   size;
    logic        exp_req, exp_pf;
    logic [31:0] exp_adr;
  } vec_t;

  vec_t vq[$];

  riscv_segmmu #(.XLEN(32), .PLEN(32), .REGIONS(4), .STAGES(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush), .enable_i(en),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_valid_i(cfg_valid), .cfg_perm_i(cfg_perm),
    .cfg_vbase_i(cfg_vbase), .cfg_mask_i(cfg_mask), .cfg_pbase_i(cfg_pbase),
    .req_i(req), .adr_i(adr), .size_i(sz), .lock_i(lock), .we_i(we),
    .req_o(o1_req), .adr_o(o1_adr), .size_o(o1_size), .lock_o(o1_lock), .we_o(o1_we),
    .pagefault_o(o1_pf)
  );

  riscv_segmmu #(.XLEN(32), .PLEN(32), .REGIONS(4), .STAGES(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush), .enable_i(en),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_valid_i(cfg_valid), .cfg_perm_i(cfg_perm),
    .cfg_vbase_i(cfg_vbase), .cfg_mask_i(cfg_mask), .cfg_pbase_i(cfg_pbase),
    .req_i(req), .adr_i(adr), .size_i(sz), .lock_i(lock), .we_i(we),
    .req_o(o2_req), .adr_o(o2_adr), .size_o(o2_size), .lock_o(o2_lock), .we_o(o2_we),
    .pagefault_o(o2_pf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input logic r, input logic p, input logic [31:0] a,
                                      input logic w, input logic l, input biu_size_t s);
    return {r, p, a, w, l, s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    else n_pass++;
  endtask

  // One clock: inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic c_we, input logic [1:0] c_idx, input logic c_valid,
                         input logic [1:0] c_perm, input logic [31:0] c_vb, input logic [31:0] c_mk,
                         input logic [31:0] c_pb, input logic v_en, input logic [31:0] v_adr,
                         input logic v_we, input logic v_lock, input biu_size_t v_sz,
                         input logic e_req, input logic e_pf, input logic [31:0] e_adr);
    vec_t v;
    v.cfg_we = c_we; v.cfg_idx = c_idx; v.cfg_valid = c_valid; v.cfg_perm = c_perm;
    v.cfg_vbase = c_vb; v.cfg_mask = c_mk; v.cfg_pbase = c_pb;
    v.en = v_en; v.adr = v_adr; v.we = v_we; v.lock = v_lock; v.size = v_sz;
    v.exp_req = e_req; v.exp_pf = e_pf; v.exp_adr = e_adr;
    vq.push_back(v);
  endtask

  task automatic write_cfg(input logic [1:0] idx, input logic v, input logic [1:0] p,
                           input logic [31:0] vb, input logic [31:0] mk, input logic [31:0] pb);
    cfg_idx = idx; cfg_valid = v; cfg_perm = p;
    cfg_vbase = vb; cfg_mask = mk; cfg_pbase = pb;
  endtask

  // Scoreboard pop for the 1-stage instance.
  task automatic sb_check(input string nm);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got %h", nm, pk(o1_req, o1_pf, o1_adr, o1_we, o1_lock, o1_size));
    end else begin
      e = exp_q.pop_front();
      chk(nm, 64'(pk(o1_req, o1_pf, o1_adr, o1_we, o1_lock, o1_size)), 64'(e));
    end
  endtask

  task automatic drive_req(input logic v_en, input logic [31:0] a, input logic w,
                           input logic l, input biu_size_t s);
    en = v_en; adr = a; we = w; lock = l; sz = s; req = 1'b1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; stall = 1'b0; flush = 1'b0; cfg_we = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; en = 1'b0;
    cfg_we = 1'b0; write_cfg(2'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    req = 1'b0; adr = '0; we = 1'b0; lock = 1'b0; sz = BYTE;

    // Reset state
    step(); step();
    chk("reset_u1", 64'(pk(o1_req, o1_pf, o1_adr, o1_we, o1_lock, o1_size)), 64'd0);
    chk("reset_u2", 64'(pk(o2_req, o2_pf, o2_adr, o2_we, o2_lock, o2_size)), 64'd0);
    rst_n = 1'b1;
    step();

    // Vector table: {cfg write}, request, expected 1-stage output
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h4000_0000, 0, 0, WORD, 0, 1, 32'h4000_0000);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h8000_1234, 1, 0, WORD, 1, 0, 32'h8000_1234);
    add_vec(1, 0, 1, 2'b11, 32'h4000_0000, 32'hF000_0000, 32'h1000_0000,
            1, 32'h4000_0ABC, 0, 0, WORD, 1, 0, 32'h1000_0ABC);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h5000_0000, 0, 0, WORD, 0, 1, 32'h5000_0000);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h5000_0000, 0, 0, BYTE, 1, 0, 32'h5000_0000);
    add_vec(1, 0, 1, 2'b01, 32'h4000_0000, 32'hF000_0000, 32'h1000_0000,
            1, 32'h4000_0000, 1, 0, WORD, 0, 1, 32'h4000_0000);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h4000_0000, 0, 0, HWORD, 1, 0, 32'h1000_0000);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h4000_0004, 0, 1, WORD, 0, 1, 32'h4000_0004);
    add_vec(1, 0, 1, 2'b11, 32'h4000_0000, 32'hF000_0000, 32'h1000_0000,
            1, 32'h4FFF_FFFC, 1, 1, WORD, 1, 0, 32'h1FFF_FFFC);
    add_vec(1, 1, 1, 2'b11, 32'h0, 32'h0, 32'h2000_0000,
            1, 32'h4000_0010, 0, 0, WORD, 1, 0, 32'h1000_0010);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h7000_0010, 0, 0, WORD, 1, 0, 32'h7000_0010);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h9000_0000, 1, 0, BYTE, 1, 0, 32'h9000_0000);
    add_vec(1, 1, 0, 2'b11, 32'h0, 32'h0, 32'h2000_0000,
            1, 32'h7000_0010, 0, 0, WORD, 0, 1, 32'h7000_0010);
    add_vec(1, 3, 1, 2'b10, 32'h7000_0000, 32'hFF00_0000, 32'hAB00_0000,
            1, 32'h7012_3456, 1, 0, WORD, 1, 0, 32'hAB12_3456);
    add_vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h7012_3456, 0, 0, WORD, 0, 1, 32'h7012_3456);

    foreach (vq[i]) begin
      if (vq[i].cfg_we) begin
        write_cfg(vq[i].cfg_idx, vq[i].cfg_valid, vq[i].cfg_perm,
                  vq[i].cfg_vbase, vq[i].cfg_mask, vq[i].cfg_pbase);
        cfg_we = 1'b1; req = 1'b0;
        step();
        cfg_we = 1'b0;
        chk($sformatf("noreq_%0d", i), 64'({o1_req, o1_pf}), 64'd0);
      end
      drive_req(vq[i].en, vq[i].adr, vq[i].we, vq[i].lock, vq[i].size);
      exp_q.push_back(pk(vq[i].exp_req, vq[i].exp_pf, vq[i].exp_adr,
                         vq[i].we, vq[i].lock, vq[i].size));
      step();
      req = 1'b0;
      sb_check($sformatf("vec_%0d", i));
    end

    // Back-to-back random bare-mode requests
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0, biu_size_t'($urandom_range(0, 2)));
      exp_q.push_back(pk(1'b1, 1'b0, adr, we, 1'b0, sz));
      step();
      sb_check($sformatf("bare_rand_%0d", i));
    end
    idle(2);

    // 2-stage latency and back-to-back throughput (hit then miss)
    drive_req(1'b1, 32'h4000_0ABC, 1'b0, 1'b0, WORD);
    step();
    chk("s2_lat_n1", 64'({o2_req, o2_pf}), 64'd0);
    drive_req(1'b1, 32'h5000_0000, 1'b0, 1'b0, WORD);
    step();
    req = 1'b0;
    chk("s2_hit_n2", 64'({o2_req, o2_pf, o2_adr}), 64'({2'b10, 32'h1000_0ABC}));
    step();
    chk("s2_miss", 64'({o2_req, o2_pf, o2_adr}), 64'({2'b01, 32'h5000_0000}));
    step();
    chk("s2_drain", 64'({o2_req, o2_pf}), 64'd0);
    idle(1);

    // Stall held 3 cycles with a request in flight
    drive_req(1'b1, 32'h4000_0ABC, 1'b0, 1'b0, WORD);
    step();
    req = 1'b0; stall = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_u1_%0d", i), 64'({o1_req, o1_adr}), 64'({1'b1, 32'h1000_0ABC}));
      if (o2_req) pulses++;
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) chk("stall_rel_adr", 64'({o2_req, o2_adr}), 64'({1'b1, 32'h1000_0ABC}));
      if (o2_req) pulses++;
    end
    chk("stall_pulses", 64'(pulses), 64'd1);
    idle(2);

    // Flush together with stall while in flight
    drive_req(1'b1, 32'h4000_0ABC, 1'b0, 1'b0, WORD);
    step();
    req = 1'b0; stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    chk("flush_u1", 64'({o1_req, o1_pf}), 64'd0);
    chk("flush_u2", 64'({o2_req, o2_pf}), 64'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o2_req || o2_pf) pulses++;
    end
    chk("flush_no_pulse", 64'(pulses), 64'd0);

    // Config hazard: invalidate entry0 in the same cycle as a lookup
    write_cfg(2'd0, 1'b0, 2'b11, 32'h4000_0000, 32'hF000_0000, 32'h1000_0000);
    cfg_we = 1'b1;
    drive_req(1'b1, 32'h4000_0000, 1'b0, 1'b0, WORD);
    step();
    cfg_we = 1'b0;
    chk("hazard_old", 64'({o1_req, o1_pf, o1_adr}), 64'({2'b10, 32'h1000_0000}));
    step();
    req = 1'b0;
    chk("hazard_new", 64'({o1_req, o1_pf, o1_adr}), 64'({2'b01, 32'h4000_0000}));
    idle(2);

    // Reset mid-request
    drive_req(1'b0, 32'h1234_5678, 1'b1, 1'b0, WORD);
    step();
    req = 1'b0;
    chk("pre_rst_u1", 64'(o1_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_u1", 64'(pk(o1_req, o1_pf, o1_adr, o1_we, o1_lock, o1_size)), 64'd0);
    chk("mid_rst_u2", 64'(pk(o2_req, o2_pf, o2_adr, o2_we, o2_lock, o2_size)), 64'd0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o1_req || o1_pf || o2_req || o2_pf) pulses++;
    end
    chk("post_rst_no_pulse", 64'(pulses), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
